// File: rtl/rv151_pkg.sv
// ----------------------------------------------------------------------------
// rv151_pkg : immediate format codes shared across the rv151 decode stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv151_pkg;

  localparam int IMM_TYPE_W = 3;

  typedef logic [IMM_TYPE_W-1:0] imm_type_t;

  localparam imm_type_t IMM_R  = 3'd0;
  localparam imm_type_t IMM_I  = 3'd1;
  localparam imm_type_t IMM_S  = 3'd2;
  localparam imm_type_t IMM_B  = 3'd3;
  localparam imm_type_t IMM_U  = 3'd4;
  localparam imm_type_t IMM_J  = 3'd5;
  localparam imm_type_t IMM_Z  = 3'd6;
  localparam imm_type_t IMM_SH = 3'd7;

endpackage

`default_nettype wire

// File: rtl/rv151_imm_pipe_if.sv
// ----------------------------------------------------------------------------
// rv151_imm_pipe_if : input/output valid-ready bus of the immediate pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rv151_imm_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  import rv151_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  imm_type_t        in_type;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type_t        out_type;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag
  );

endinterface

`default_nettype wire

// File: rtl/rv151_imm_dec.sv
// ----------------------------------------------------------------------------
// rv151_imm_dec : combinational immediate extraction and extension to XLEN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv151_imm_dec
  import rv151_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [31:0]     inst_i,
  input  wire imm_type_t       type_i,
  output logic      [XLEN-1:0] imm_o
);

  logic [31:0] w_raw;
  logic        w_sext;
  logic        w_unused;

  // opcode bits never contribute to any immediate
  assign w_unused = ^inst_i[6:0];

  always_comb begin
    w_raw  = '0;
    w_sext = 1'b1;
    case (type_i)
      IMM_I:   w_raw = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   w_raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   w_raw = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   w_raw = {inst_i[31:12], 12'h000};
      IMM_J:   w_raw = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      IMM_Z: begin
        w_raw  = {27'b0, inst_i[19:15]};
        w_sext = 1'b0;
      end
      IMM_SH: begin
        w_raw  = (XLEN == 64) ? {26'b0, inst_i[25:20]} : {27'b0, inst_i[24:20]};
        w_sext = 1'b0;
      end
      default: begin
        w_raw  = '0;
        w_sext = 1'b0;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm_o = {{(XLEN-32){w_sext & w_raw[31]}}, w_raw};
    end else begin : g_narrow
      assign imm_o = w_raw;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rv151_imm_pipe.sv
// ----------------------------------------------------------------------------
// rv151_imm_pipe : registered immediate generator with output reg + skid buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv151_imm_pipe
  import rv151_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  input wire logic          flush,
  rv151_imm_pipe_if.slave   bus
);

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_in_fire;
  logic             w_out_free;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  imm_type_t        out_type_q,  out_type_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  imm_type_t        skid_type_q,  skid_type_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  rv151_imm_dec #(
    .XLEN (XLEN)
  ) u_dec (
    .inst_i (bus.in_inst),
    .type_i (bus.in_type),
    .imm_o  (w_dec_imm)
  );

  // ready comes from state only, so it never combinationally follows out_ready
  assign bus.in_ready = !skid_valid_q && !rst;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_out_free   = !out_valid_q || bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_type_d   = out_type_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        // skid is older than anything at the input, so it drains first
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_type_d   = skid_type_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = w_in_fire;
        if (w_in_fire) begin
          out_imm_d  = w_dec_imm;
          out_type_d = bus.in_type;
          out_tag_d  = bus.in_tag;
        end
      end
    end else if (w_in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = w_dec_imm;
      skid_type_d  = bus.in_type;
      skid_tag_d   = bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_type_q   <= IMM_R;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_type_q  <= IMM_R;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_type_q   <= out_type_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_type_q  <= skid_type_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_type  = out_type_q;
  assign bus.out_tag   = out_tag_q;

endmodule

`default_nettype wire

// File: doc/rv151_imm_pipe.md
# rv151_imm_pipe

Registered, flow-controlled immediate generator for the rv151 decode stage. It accepts one instruction word per cycle with a type code and a sideband tag, and returns the sign/zero-extended immediate one cycle later on a valid/ready interface. It generalises immediate extraction to XLEN 32/64, adds CSR-zimm and shift-amount formats, and adds a two-entry skid buffer so decode can be stalled or flushed without losing or duplicating instructions.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag (PC or ROB id) carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an input entry.
- in_inst  in  32  instruction word.
- in_type  in  3  immediate format code.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  format code of the output entry.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- Format codes (i = in_inst; sx = sign-extend from i[31] to XLEN):
  - 0 R: all zeros.
  - 1 I: sx(i[31:20]).
  - 2 S: sx({i[31:25], i[11:7]}).
  - 3 B: sx({i[31], i[7], i[30:25], i[11:8], 0}).
  - 4 U: sx({i[31:12], 12'h0}). For XLEN=32 this is the raw value.
  - 5 J: sx({i[31], i[19:12], i[20], i[30:21], 0}).
  - 6 Z: zero-extend i[19:15] (CSR immediate).
  - 7 SH: zero-extend i[25:20] when XLEN=64; zero-extend i[24:20] when XLEN=32.
- Decode happens combinationally on the input. Only decoded results are stored; the raw instruction is not stored.
- Storage consists of an output register (out_*) and one skid register. Entries leave in acceptance order.
- in_ready = !skid_valid && !rst. It is a register output only and never depends combinationally on out_ready.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Output register load: when the output register is empty or being drained, it loads from the skid if the skid holds an entry, otherwise from the input transfer (if any).
- Skid load: the skid captures the input transfer when the output register is full and not being drained.
- Simultaneous input and output transfer with the skid empty: the output register is replaced and the skid stays empty. Throughput is one entry per cycle.
- flush has priority over everything. Both valids are cleared at the next edge, and any input transfer in the flush cycle is dropped. An output transfer in the flush cycle still counts as consumed.
- out_imm, out_type and out_tag hold their value while out_valid && !out_ready.

## Timing
- Latency: an input accepted at edge N is visible on out_* after edge N when the path is empty.
- Reset values: out_valid=0, out_imm=0, out_type=0, out_tag=0, skid empty. in_ready=0 while rst is high and 1 in the first cycle after release.
- Reset asserted mid-stream drops all entries at that edge. No partial entry survives.
- Full condition: output register and skid both occupied, so in_ready=0. in_ready returns to 1 one cycle after the first output transfer.
- out_valid never deasserts without an output transfer, except on flush or rst.

## Structure
- Shared package rv151_pkg holds the format-code localparams IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH and the IMM_TYPE_W = 3 constant.
- One sub-module, rv151_imm_dec: purely combinational, parameterised by XLEN, instantiated once on the input path. The top level contains only the skid/output registers and the handshake logic.

## Test plan
- Encoding check, XLEN=32 (one entry each, out_ready=1):
  - I, 0xFFF00093 → out_imm 0xFFFFFFFF.
  - B, 0xFE000EE3 → 0xFFFFFFFC.
  - U, 0x123452B7 → 0x12345000.
  - SH, 0x01F01093 → 0x1F.
- Encoding check, XLEN=64:
  - U, 0x800002B7 → 0xFFFFFFFF80000000.
  - SH, 0x03F01093 → 0x3F.
  - Z, 0x000FD073 → 0x1F.
  - R, any word → 0.
- Backpressure: 4 back-to-back inputs tagged 1..4 with out_ready=0 for 3 cycles. Required: in_ready=0 after 2 accepts, out_tag held at 1, then tags 1,2,3,4 delivered in order with no gaps once out_ready=1.
- Streaming: 16 inputs with in_valid and out_ready constantly high → 16 outputs on consecutive cycles, 1-cycle latency, in_ready never low.
- Flush: skid and output register both full, flush pulsed together with in_valid=1 (tag 9) → out_valid=0 and in_ready=1 next cycle, and tag 9 never appears.
- Reset mid-stream: rst asserted for 1 cycle while full → all outputs at reset values and in_ready=0 during rst; the next accepted entry appears with 1-cycle latency.
